// File: rtl/axi4_modport_pkg.sv
// Shared constants for the AXI4 link monitor: channel indices, payload field
// widths and response encodings.
package axi4_modport_pkg;

   localparam int CH_AW  = 0;
   localparam int CH_W   = 1;
   localparam int CH_B   = 2;
   localparam int CH_AR  = 3;
   localparam int CH_R   = 4;
   localparam int NUM_CH = 5;

   // len + size + burst + cache + prot + qos + region on AW/AR
   localparam int AX_CTRL_W = 8 + 3 + 2 + 4 + 3 + 4 + 4;
   localparam int RESP_W    = 2;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   function automatic logic any_err(input logic [NUM_CH-1:0] stable_err,
                                    input logic [NUM_CH-1:0] drop_err);
      return |{stable_err, drop_err};
   endfunction

endpackage

// File: rtl/axi4_modport_chan_mon.sv
// One AXI4 channel monitor: handshake / last-beat counters plus sticky flags
// for payload changes and VALID withdrawal during a stall.
module axi4_chan_mon
   import axi4_modport_pkg::*;
#(
   parameter int PAYLOAD_WIDTH = 8,
   parameter bit HAS_LAST      = 1'b0,
   parameter int CNT_WIDTH     = 32
) (
   input  logic                     aclk_i,
   input  logic                     areset_n_i,
   input  logic                     valid_i,
   input  logic                     ready_i,
   input  logic                     last_i,
   input  logic [PAYLOAD_WIDTH-1:0] payload_i,
   output logic [CNT_WIDTH-1:0]     count_o,
   output logic [CNT_WIDTH-1:0]     last_count_o,
   output logic                     err_stable_o,
   output logic                     err_valid_drop_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic                     hs;
   logic                     last_hs;
   logic [CNT_WIDTH-1:0]     cnt_d, cnt_q;
   logic [CNT_WIDTH-1:0]     last_cnt_d, last_cnt_q;
   logic                     stall_d, stall_q;
   logic [PAYLOAD_WIDTH-1:0] snap_q;
   logic                     err_stable_d, err_stable_q;
   logic                     err_drop_d, err_drop_q;

   always_comb begin
      hs         = valid_i & ready_i;
      last_hs    = hs & last_i & HAS_LAST;
      cnt_d      = hs      ? cnt_q + CNT_ONE      : cnt_q;
      last_cnt_d = last_hs ? last_cnt_q + CNT_ONE : last_cnt_q;
      stall_d    = valid_i & ~ready_i;
      // The snapshot is only meaningful when the previous cycle was a stall.
      err_stable_d = err_stable_q | (stall_q & valid_i & (payload_i != snap_q));
      err_drop_d   = err_drop_q   | (stall_q & ~valid_i);
   end

   always_ff @(posedge aclk_i) begin
      if (!areset_n_i) begin
         cnt_q        <= '0;
         last_cnt_q   <= '0;
         stall_q      <= 1'b0;
         snap_q       <= '0;
         err_stable_q <= 1'b0;
         err_drop_q   <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         last_cnt_q   <= last_cnt_d;
         stall_q      <= stall_d;
         snap_q       <= payload_i;
         err_stable_q <= err_stable_d;
         err_drop_q   <= err_drop_d;
      end
   end

   assign count_o          = cnt_q;
   assign last_count_o     = last_cnt_q;
   assign err_stable_o     = err_stable_q;
   assign err_valid_drop_o = err_drop_q;

endmodule

// File: rtl/axi4_modport.sv
// Passive AXI4 link monitor: five channel monitors fed with concatenated
// payloads; drives nothing onto the bus.
module axi4_modport
   import axi4_modport_pkg::*;
#(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  aclk,
   input  logic                  areset_n,
   // AW
   input  logic                  aw_valid,
   input  logic                  aw_ready,
   input  logic [ID_WIDTH-1:0]   aw_id,
   input  logic [ADDR_WIDTH-1:0] aw_addr,
   input  logic [7:0]            aw_len,
   input  logic [2:0]            aw_size,
   input  logic [1:0]            aw_burst,
   input  logic [3:0]            aw_cache,
   input  logic [2:0]            aw_prot,
   input  logic [3:0]            aw_qos,
   input  logic [3:0]            aw_region,
   // W
   input  logic                  w_valid,
   input  logic                  w_ready,
   input  logic                  w_last,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic [STRB_WIDTH-1:0] w_strb,
   // B
   input  logic                  b_valid,
   input  logic                  b_ready,
   input  logic [ID_WIDTH-1:0]   b_id,
   input  logic [1:0]            b_resp,
   // AR
   input  logic                  ar_valid,
   input  logic                  ar_ready,
   input  logic [ID_WIDTH-1:0]   ar_id,
   input  logic [ADDR_WIDTH-1:0] ar_addr,
   input  logic [7:0]            ar_len,
   input  logic [2:0]            ar_size,
   input  logic [1:0]            ar_burst,
   input  logic [3:0]            ar_cache,
   input  logic [2:0]            ar_prot,
   input  logic [3:0]            ar_qos,
   input  logic [3:0]            ar_region,
   // R
   input  logic                  r_valid,
   input  logic                  r_ready,
   input  logic                  r_last,
   input  logic [ID_WIDTH-1:0]   r_id,
   input  logic [DATA_WIDTH-1:0] r_data,
   input  logic [1:0]            r_resp,
   // Status
   output logic [CNT_WIDTH-1:0]  aw_count,
   output logic [CNT_WIDTH-1:0]  ar_count,
   output logic [CNT_WIDTH-1:0]  w_count,
   output logic [CNT_WIDTH-1:0]  b_count,
   output logic [CNT_WIDTH-1:0]  r_count,
   output logic [CNT_WIDTH-1:0]  w_last_count,
   output logic [CNT_WIDTH-1:0]  r_last_count,
   output logic [NUM_CH-1:0]     err_stable,
   output logic [NUM_CH-1:0]     err_valid_drop,
   output logic                  err_any
);

   localparam int AX_PL_W = ID_WIDTH + ADDR_WIDTH + AX_CTRL_W;
   localparam int W_PL_W  = DATA_WIDTH + STRB_WIDTH + 1;
   localparam int B_PL_W  = ID_WIDTH + RESP_W;
   localparam int R_PL_W  = ID_WIDTH + DATA_WIDTH + RESP_W + 1;

   logic [AX_PL_W-1:0] aw_pl, ar_pl;
   logic [W_PL_W-1:0]  w_pl;
   logic [B_PL_W-1:0]  b_pl;
   logic [R_PL_W-1:0]  r_pl;

   // Channels without a last signal still carry a last counter; it stays 0.
   logic [CNT_WIDTH-1:0] unused_aw_last_cnt, unused_b_last_cnt, unused_ar_last_cnt;

   assign aw_pl = {aw_id, aw_addr, aw_len, aw_size, aw_burst,
                   aw_cache, aw_prot, aw_qos, aw_region};
   assign ar_pl = {ar_id, ar_addr, ar_len, ar_size, ar_burst,
                   ar_cache, ar_prot, ar_qos, ar_region};
   assign w_pl  = {w_data, w_strb, w_last};
   assign b_pl  = {b_id, b_resp};
   assign r_pl  = {r_id, r_data, r_resp, r_last};

   axi4_chan_mon #(.PAYLOAD_WIDTH(AX_PL_W), .HAS_LAST(1'b0), .CNT_WIDTH(CNT_WIDTH)) u_aw (
      .aclk_i(aclk), .areset_n_i(areset_n),
      .valid_i(aw_valid), .ready_i(aw_ready), .last_i(1'b0), .payload_i(aw_pl),
      .count_o(aw_count), .last_count_o(unused_aw_last_cnt),
      .err_stable_o(err_stable[CH_AW]), .err_valid_drop_o(err_valid_drop[CH_AW])
   );

   axi4_chan_mon #(.PAYLOAD_WIDTH(W_PL_W), .HAS_LAST(1'b1), .CNT_WIDTH(CNT_WIDTH)) u_w (
      .aclk_i(aclk), .areset_n_i(areset_n),
      .valid_i(w_valid), .ready_i(w_ready), .last_i(w_last), .payload_i(w_pl),
      .count_o(w_count), .last_count_o(w_last_count),
      .err_stable_o(err_stable[CH_W]), .err_valid_drop_o(err_valid_drop[CH_W])
   );

   axi4_chan_mon #(.PAYLOAD_WIDTH(B_PL_W), .HAS_LAST(1'b0), .CNT_WIDTH(CNT_WIDTH)) u_b (
      .aclk_i(aclk), .areset_n_i(areset_n),
      .valid_i(b_valid), .ready_i(b_ready), .last_i(1'b0), .payload_i(b_pl),
      .count_o(b_count), .last_count_o(unused_b_last_cnt),
      .err_stable_o(err_stable[CH_B]), .err_valid_drop_o(err_valid_drop[CH_B])
   );

   axi4_chan_mon #(.PAYLOAD_WIDTH(AX_PL_W), .HAS_LAST(1'b0), .CNT_WIDTH(CNT_WIDTH)) u_ar (
      .aclk_i(aclk), .areset_n_i(areset_n),
      .valid_i(ar_valid), .ready_i(ar_ready), .last_i(1'b0), .payload_i(ar_pl),
      .count_o(ar_count), .last_count_o(unused_ar_last_cnt),
      .err_stable_o(err_stable[CH_AR]), .err_valid_drop_o(err_valid_drop[CH_AR])
   );

   axi4_chan_mon #(.PAYLOAD_WIDTH(R_PL_W), .HAS_LAST(1'b1), .CNT_WIDTH(CNT_WIDTH)) u_r (
      .aclk_i(aclk), .areset_n_i(areset_n),
      .valid_i(r_valid), .ready_i(r_ready), .last_i(r_last), .payload_i(r_pl),
      .count_o(r_count), .last_count_o(r_last_count),
      .err_stable_o(err_stable[CH_R]), .err_valid_drop_o(err_valid_drop[CH_R])
   );

   assign err_any = any_err(err_stable, err_valid_drop);

endmodule

// File: tb/tb_axi4_modport.sv
// Bench for axi4_modport: a per-cycle scoreboard of expected status plus
// targeted scenario checks, with 4-bit counters so wrap is reachable.
module tb_axi4_modport;
   import axi4_modport_pkg::*;

   localparam int CW = 4;

   logic aclk = 1'b0;
   logic areset_n;
   logic aw_valid, aw_ready, ar_valid, ar_ready, w_valid, w_ready, w_last;
   logic b_valid, b_ready, r_valid, r_ready, r_last;
   logic [3:0]  aw_id, ar_id, b_id, r_id;
   logic [63:0] aw_addr, ar_addr, w_data, r_data;
   logic [7:0]  aw_len, ar_len, w_strb;
   logic [2:0]  aw_size, ar_size, aw_prot, ar_prot;
   logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
   logic [3:0]  aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region;
   logic [CW-1:0] aw_count, ar_count, w_count, b_count, r_count, w_last_count, r_last_count;
   logic [4:0] err_stable, err_valid_drop;
   logic err_any;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [CW-1:0] aw, w, b, ar, r, wl, rl;
      logic [4:0]    es, ed;
      logic          any;
   } obs_t;

   obs_t exp_q[$];

   // Bench-side reference state
   int unsigned m_cnt[5];
   int unsigned m_wl, m_rl;
   logic [4:0]   m_es, m_ed, m_stall;
   logic [255:0] m_snap[5];

   axi4_modport #(.CNT_WIDTH(CW)) dut (
      .aclk(aclk), .areset_n(areset_n),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
      .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst), .aw_cache(aw_cache),
      .aw_prot(aw_prot), .aw_qos(aw_qos), .aw_region(aw_region),
      .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last), .w_data(w_data), .w_strb(w_strb),
      .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
      .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst), .ar_cache(ar_cache),
      .ar_prot(ar_prot), .ar_qos(ar_qos), .ar_region(ar_region),
      .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last), .r_id(r_id),
      .r_data(r_data), .r_resp(r_resp),
      .aw_count(aw_count), .ar_count(ar_count), .w_count(w_count), .b_count(b_count),
      .r_count(r_count), .w_last_count(w_last_count), .r_last_count(r_last_count),
      .err_stable(err_stable), .err_valid_drop(err_valid_drop), .err_any(err_any)
   );

   always #5 aclk = ~aclk;

   task automatic model_step();
      logic [255:0] pl[5];
      logic v[5];
      logic rd[5];
      pl[0] = 256'({aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_cache, aw_prot, aw_qos, aw_region});
      pl[1] = 256'({w_data, w_strb, w_last});
      pl[2] = 256'({b_id, b_resp});
      pl[3] = 256'({ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_cache, ar_prot, ar_qos, ar_region});
      pl[4] = 256'({r_id, r_data, r_resp, r_last});
      v  = '{aw_valid, w_valid, b_valid, ar_valid, r_valid};
      rd = '{aw_ready, w_ready, b_ready, ar_ready, r_ready};
      if (!areset_n) begin
         for (int c = 0; c < 5; c++) begin m_cnt[c] = 0; m_snap[c] = '0; end
         m_wl = 0; m_rl = 0; m_es = '0; m_ed = '0; m_stall = '0;
      end else begin
         if (w_valid && w_ready && w_last) m_wl++;
         if (r_valid && r_ready && r_last) m_rl++;
         for (int c = 0; c < 5; c++) begin
            if (v[c] && rd[c]) m_cnt[c]++;
            if (m_stall[c] && v[c] && pl[c] != m_snap[c]) m_es[c] = 1'b1;
            if (m_stall[c] && !v[c]) m_ed[c] = 1'b1;
            m_stall[c] = v[c] && !rd[c];
            m_snap[c]  = pl[c];
         end
      end
   endtask

   // One clock: update the reference at the edge, push, then compare just after.
   task automatic cyc();
      obs_t e, a;
      @(posedge aclk);
      model_step();
      exp_q.push_back({CW'(m_cnt[0]), CW'(m_cnt[1]), CW'(m_cnt[2]), CW'(m_cnt[3]),
                       CW'(m_cnt[4]), CW'(m_wl), CW'(m_rl), m_es, m_ed, |{m_es, m_ed}});
      #1;
      a = {aw_count, w_count, b_count, ar_count, r_count, w_last_count, r_last_count,
           err_stable, err_valid_drop, err_any};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty got %h", a);
      end else begin
         e = exp_q.pop_front();
         if (a !== e) begin
            errors++;
            $display("FAIL scoreboard t=%0t got %h want %h", $time, a, e);
         end
      end
   endtask

   task automatic idle();
      aw_valid = 0; aw_ready = 0; w_valid = 0; w_ready = 0; w_last = 0;
      b_valid = 0; b_ready = 0; ar_valid = 0; ar_ready = 0;
      r_valid = 0; r_ready = 0; r_last = 0;
   endtask

   task automatic do_reset();
      idle();
      areset_n = 0;
      cyc();
      areset_n = 1;
   endtask

   task automatic test_reset();
      aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 3'd3; aw_burst = 2'b01; aw_cache = 0;
      aw_prot = 0; aw_qos = 0; aw_region = 0;
      ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 3'd3; ar_burst = 2'b01; ar_cache = 0;
      ar_prot = 0; ar_qos = 0; ar_region = 0;
      w_data = 0; w_strb = 8'hff; b_id = 0; b_resp = RESP_OKAY;
      r_id = 0; r_data = 0; r_resp = RESP_OKAY;
      idle();
      areset_n = 0;
      cyc();
      cyc();
      checks++;
      if ({aw_count, ar_count, w_count, b_count, r_count, w_last_count, r_last_count,
           err_stable, err_valid_drop, err_any} !== '0) begin
         errors++;
         $display("FAIL reset_state got aw=%0d ar=%0d w=%0d b=%0d r=%0d es=%b ed=%b any=%b want all 0",
                  aw_count, ar_count, w_count, b_count, r_count, err_stable, err_valid_drop, err_any);
      end
      areset_n = 1;
   endtask

   task automatic test_back_to_back();
      do_reset();
      aw_valid = 1; aw_ready = 1; ar_valid = 1; ar_ready = 1;
      b_valid = 1; b_ready = 1; b_resp = RESP_EXOKAY; b_id = 4'h5;
      for (int i = 0; i < 3; i++) begin
         aw_addr = 64'h100 * i; aw_id = 4'(i);
         ar_addr = 64'h200 * i; ar_id = 4'(i + 8);
         cyc();
         b_valid = 0;
      end
      idle();
      cyc();
      checks++;
      if ({aw_count, ar_count, b_count, err_stable, err_valid_drop}
          !== {4'd3, 4'd3, 4'd1, 5'd0, 5'd0}) begin
         errors++;
         $display("FAIL back_to_back got aw=%0d ar=%0d b=%0d es=%b ed=%b want 3 3 1 00000 00000",
                  aw_count, ar_count, b_count, err_stable, err_valid_drop);
      end
   endtask

   task automatic test_w_burst();
      do_reset();
      w_valid = 1; w_strb = 8'hff;
      for (int beat = 0; beat < 4; beat++) begin
         w_data = {$urandom, $urandom};
         w_last = (beat == 3);
         if (beat == 2) begin
            w_ready = 0;
            cyc();
            cyc();
         end
         w_ready = 1;
         cyc();
      end
      idle();
      cyc();
      checks++;
      if ({w_count, w_last_count, err_stable} !== {4'd4, 4'd1, 5'd0}) begin
         errors++;
         $display("FAIL w_burst got w=%0d wl=%0d es=%b want 4 1 00000",
                  w_count, w_last_count, err_stable);
      end
   endtask

   task automatic test_ar_stable();
      do_reset();
      ar_valid = 1; ar_ready = 0; ar_addr = 64'h1000;
      cyc();
      ar_addr = 64'h2000;
      cyc();
      checks++;
      if ({err_stable, err_any} !== {5'b01000, 1'b1}) begin
         errors++;
         $display("FAIL ar_stable got es=%b any=%b want 01000 1", err_stable, err_any);
      end
      ar_ready = 1;
      cyc();
      idle();
      cyc();
      cyc();
      checks++;
      if ({err_stable, err_valid_drop, err_any} !== {5'b01000, 5'b00000, 1'b1}) begin
         errors++;
         $display("FAIL ar_sticky got es=%b ed=%b any=%b want 01000 00000 1",
                  err_stable, err_valid_drop, err_any);
      end
   endtask

   task automatic test_r_drop();
      do_reset();
      r_valid = 1; r_ready = 0; r_data = 64'hdead_beef_0000_0001; r_last = 1;
      cyc();
      r_valid = 0;
      cyc();
      checks++;
      if ({err_valid_drop, err_stable, err_any, r_count} !== {5'b10000, 5'b00000, 1'b1, 4'd0}) begin
         errors++;
         $display("FAIL r_drop got ed=%b es=%b any=%b r=%0d want 10000 00000 1 0",
                  err_valid_drop, err_stable, err_any, r_count);
      end
   endtask

   task automatic test_multi();
      do_reset();
      aw_valid = 1; aw_ready = 0; aw_addr = 64'h40; b_valid = 1; b_ready = 0;
      r_valid = 1; r_ready = 1; r_last = 1;
      cyc();
      aw_len = 8'd7; b_valid = 0; r_data = 64'h1234;
      cyc();
      checks++;
      if ({err_stable, err_valid_drop, r_count, r_last_count}
          !== {5'b00001, 5'b00100, 4'd2, 4'd2}) begin
         errors++;
         $display("FAIL multi got es=%b ed=%b r=%0d rl=%0d want 00001 00100 2 2",
                  err_stable, err_valid_drop, r_count, r_last_count);
      end
      aw_ready = 1;
      cyc();
      idle();
      aw_len = 0;
   endtask

   task automatic test_wrap();
      do_reset();
      b_valid = 1; b_ready = 1;
      for (int i = 0; i < 17; i++) begin
         b_id = 4'(i);
         b_resp = (i % 2 == 0) ? RESP_OKAY : RESP_SLVERR;
         cyc();
      end
      idle();
      cyc();
      checks++;
      if (b_count !== 4'd1) begin
         errors++;
         $display("FAIL wrap got b=%0d want 1", b_count);
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      w_valid = 1; w_ready = 0; w_data = 64'haaaa; w_last = 0;
      cyc();
      cyc();
      areset_n = 0;
      cyc();
      checks++;
      if ({w_count, err_stable, err_valid_drop, err_any} !== '0) begin
         errors++;
         $display("FAIL mid_stall_reset got w=%0d es=%b ed=%b any=%b want all 0",
                  w_count, err_stable, err_valid_drop, err_any);
      end
      areset_n = 1;
      w_data = 64'h5555;
      cyc();
      cyc();
      w_ready = 1;
      cyc();
      idle();
      cyc();
      checks++;
      if ({w_count, err_stable, err_valid_drop, err_any} !== {4'd1, 5'd0, 5'd0, 1'b0}) begin
         errors++;
         $display("FAIL after_reset_stall got w=%0d es=%b ed=%b any=%b want 1 00000 00000 0",
                  w_count, err_stable, err_valid_drop, err_any);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_w_burst();
      test_ar_stable();
      test_r_drop();
      test_multi();
      test_wrap();
      test_reset_mid_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
